// File: rtl/lieat_ifu_pcgen.sv
// lieat_ifu_pcgen: next-fetch-PC generator for the IFU.
// Takes the predecode fields of the instruction at the head of the fetch
// buffer and applies static prediction to pick the next fetch address:
// JAL is always taken, conditional branches are taken only when backward,
// JALR is taken once its base register can be read, and ecall/mret
// targets come from a CSR. FENCE.I stalls fetch until the ICache reports
// that invalidation is complete. An EXU flush overrides everything.
//
//  state          | meaning
//  ---------------+----------------------------------------------------------
//  ST_RUN         | fetch request valid, instructions accepted and predicted
//  ST_WAIT_RS1    | JALR accepted, base register busy; retry read every cycle
//  ST_WAIT_CSR    | CSR read issued last cycle; its data arrives this cycle
//  ST_WAIT_FENCEI | FENCE.I accepted; wait for invalidate/drain completion
module lieat_ifu_pcgen #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = 'h8000_0000
) (
    input  logic              clock_i,
    input  logic              reset_i,

    input  logic              inst_valid_i,
    output logic              inst_ready_o,
    input  logic [XLEN-1:0]   inst_pc_i,

    input  logic              dec_jal_i,
    input  logic              dec_jalr_i,
    input  logic              dec_bxx_i,
    input  logic              dec_csr_i,
    input  logic              dec_fencei_i,
    input  logic [XLEN-1:0]   dec_immb_i,
    input  logic [4:0]        dec_rs1_i,
    input  logic              dec_rs1en_i,
    input  logic [11:0]       dec_csridx_i,

    output logic              rs1_req_o,
    output logic [4:0]        rs1_idx_o,
    input  logic              rs1_busy_i,
    input  logic [XLEN-1:0]   rs1_rdata_i,

    output logic              csr_req_o,
    output logic [11:0]       csr_idx_o,
    input  logic [XLEN-1:0]   csr_rdata_i,

    input  logic              fencei_done_i,

    input  logic              flush_i,
    input  logic [XLEN-1:0]   flush_pc_i,

    output logic              npc_valid_o,
    input  logic              npc_ready_i,
    output logic [XLEN-1:0]   npc_o,

    output logic              pred_taken_o,
    output logic [XLEN-1:0]   pred_pc_o
);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_WAIT_RS1    = 2'd1,
        ST_WAIT_CSR    = 2'd2,
        ST_WAIT_FENCEI = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] MASK_LS1 = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] MASK_LS2 = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [11:0]     CSR_MTVEC = 12'h305;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   npc_q, npc_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [4:0]        rs1_idx_q, rs1_idx_d;
    logic              rs1en_q, rs1en_d;
    logic [11:0]       csr_idx_q, csr_idx_d;
    logic              pred_taken_q, pred_taken_d;
    logic [XLEN-1:0]   pred_pc_q, pred_pc_d;

    logic              inst_ready;
    logic              rs1_req;
    logic [4:0]        rs1_idx;
    logic              csr_req;
    logic [11:0]       csr_idx;
    logic              npc_valid;

    // Candidate targets; all adders wrap modulo 2^XLEN.
    logic [XLEN-1:0]   seq_pc;
    logic [XLEN-1:0]   rel_pc;
    logic [XLEN-1:0]   jalr_now_pc;
    logic [XLEN-1:0]   jalr_held_pc;
    logic [XLEN-1:0]   csr_pc;
    logic [XLEN-1:0]   fencei_pc;
    logic              busy_now;
    logic              busy_held;

    // With rs1 disabled the JALR base is x0: never busy, value zero.
    assign busy_now     = rs1_busy_i & dec_rs1en_i;
    assign busy_held    = rs1_busy_i & rs1en_q;
    assign seq_pc       = inst_pc_i + PC_STEP;
    assign rel_pc       = inst_pc_i + dec_immb_i;
    assign jalr_now_pc  = ((dec_rs1en_i ? rs1_rdata_i : '0) + dec_immb_i) & MASK_LS1;
    assign jalr_held_pc = ((rs1en_q ? rs1_rdata_i : '0) + imm_q) & MASK_LS1;
    // mtvec (ecall) is word aligned; mepc (mret) only halfword aligned.
    assign csr_pc       = (csr_idx_q == CSR_MTVEC) ? (csr_rdata_i & MASK_LS2)
                                                   : (csr_rdata_i & MASK_LS1);
    assign fencei_pc    = pc_q + PC_STEP;

    // Next-state, next-PC and handshake/request decode.
    always_comb begin
        state_d      = state_q;
        npc_d        = npc_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        rs1_idx_d    = rs1_idx_q;
        rs1en_d      = rs1en_q;
        csr_idx_d    = csr_idx_q;
        pred_taken_d = pred_taken_q;
        pred_pc_d    = pred_pc_q;
        inst_ready   = 1'b0;
        rs1_req      = 1'b0;
        rs1_idx      = rs1_idx_q;
        csr_req      = 1'b0;
        csr_idx      = csr_idx_q;
        npc_valid    = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                npc_valid  = 1'b1;
                rs1_idx    = dec_rs1_i;
                csr_idx    = dec_csridx_i;
                inst_ready = inst_valid_i & npc_ready_i & ~flush_i;
                if (inst_ready) begin
                    if (dec_jal_i) begin
                        npc_d        = rel_pc;
                        pred_taken_d = 1'b1;
                        pred_pc_d    = rel_pc;
                    end else if (dec_jalr_i) begin
                        rs1_req = 1'b1;
                        if (!busy_now) begin
                            npc_d        = jalr_now_pc;
                            pred_taken_d = 1'b1;
                            pred_pc_d    = jalr_now_pc;
                        end else begin
                            state_d   = ST_WAIT_RS1;
                            imm_d     = dec_immb_i;
                            rs1_idx_d = dec_rs1_i;
                            rs1en_d   = dec_rs1en_i;
                        end
                    end else if (dec_bxx_i) begin
                        if (dec_immb_i[XLEN-1]) begin
                            npc_d        = rel_pc;
                            pred_taken_d = 1'b1;
                            pred_pc_d    = rel_pc;
                        end else begin
                            npc_d        = seq_pc;
                            pred_taken_d = 1'b0;
                            pred_pc_d    = seq_pc;
                        end
                    end else if (dec_csr_i) begin
                        csr_req   = 1'b1;
                        csr_idx_d = dec_csridx_i;
                        state_d   = ST_WAIT_CSR;
                    end else if (dec_fencei_i) begin
                        pc_d    = inst_pc_i;
                        state_d = ST_WAIT_FENCEI;
                    end else begin
                        npc_d        = seq_pc;
                        pred_taken_d = 1'b0;
                        pred_pc_d    = seq_pc;
                    end
                end
            end

            ST_WAIT_RS1: begin
                rs1_req = 1'b1;
                if (!busy_held) begin
                    npc_d        = jalr_held_pc;
                    pred_taken_d = 1'b1;
                    pred_pc_d    = jalr_held_pc;
                    state_d      = ST_RUN;
                end
            end

            ST_WAIT_CSR: begin
                npc_d        = csr_pc;
                pred_taken_d = 1'b1;
                pred_pc_d    = csr_pc;
                state_d      = ST_RUN;
            end

            ST_WAIT_FENCEI: begin
                if (fencei_done_i) begin
                    npc_d        = fencei_pc;
                    pred_taken_d = 1'b0;
                    pred_pc_d    = fencei_pc;
                    state_d      = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Redirect beats any resolution completing in the same cycle.
        if (flush_i) begin
            state_d      = ST_RUN;
            npc_d        = flush_pc_i;
            pred_taken_d = 1'b0;
            pred_pc_d    = pred_pc_q;
        end
    end

    // State, fetch address and latched operands of pending work.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_RUN;
            npc_q        <= RESET_PC;
            imm_q        <= '0;
            pc_q         <= '0;
            rs1_idx_q    <= '0;
            rs1en_q      <= 1'b0;
            csr_idx_q    <= '0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            npc_q        <= npc_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            rs1_idx_q    <= rs1_idx_d;
            rs1en_q      <= rs1en_d;
            csr_idx_q    <= csr_idx_d;
            pred_taken_q <= pred_taken_d;
            pred_pc_q    <= pred_pc_d;
        end
    end

    assign inst_ready_o = inst_ready;
    assign rs1_req_o    = rs1_req;
    assign rs1_idx_o    = rs1_idx;
    assign csr_req_o    = csr_req;
    assign csr_idx_o    = csr_idx;
    assign npc_valid_o  = npc_valid;
    assign npc_o        = npc_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_pc_o    = pred_pc_q;

endmodule

// File: tb/tb_lieat_ifu_pcgen.sv
// Testbench for lieat_ifu_pcgen: directed scenarios followed by random
// instruction traffic. Expected fetch targets come from a reference model
// and are queued; a monitor pops them as the DUT presents each new address.
module tb_lieat_ifu_pcgen;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    localparam int C_NONE   = 0;
    localparam int C_JAL    = 1;
    localparam int C_BXX    = 2;
    localparam int C_JALR   = 3;
    localparam int C_CSR    = 4;
    localparam int C_FENCEI = 5;

    logic        clock, reset;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_pc;
    logic        dec_jal, dec_jalr, dec_bxx, dec_csr, dec_fencei;
    logic [31:0] dec_immb;
    logic [4:0]  dec_rs1;
    logic        dec_rs1en;
    logic [11:0] dec_csridx;
    logic        rs1_req;
    logic [4:0]  rs1_idx;
    logic        rs1_busy;
    logic [31:0] rs1_rdata;
    logic        csr_req;
    logic [11:0] csr_idx;
    logic [31:0] csr_rdata;
    logic        fencei_done;
    logic        flush;
    logic [31:0] flush_pc;
    logic        npc_valid, npc_ready;
    logic [31:0] npc;
    logic        pred_taken;
    logic [31:0] pred_pc;

    lieat_ifu_pcgen #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clock_i(clock), .reset_i(reset),
        .inst_valid_i(inst_valid), .inst_ready_o(inst_ready), .inst_pc_i(inst_pc),
        .dec_jal_i(dec_jal), .dec_jalr_i(dec_jalr), .dec_bxx_i(dec_bxx),
        .dec_csr_i(dec_csr), .dec_fencei_i(dec_fencei), .dec_immb_i(dec_immb),
        .dec_rs1_i(dec_rs1), .dec_rs1en_i(dec_rs1en), .dec_csridx_i(dec_csridx),
        .rs1_req_o(rs1_req), .rs1_idx_o(rs1_idx), .rs1_busy_i(rs1_busy),
        .rs1_rdata_i(rs1_rdata),
        .csr_req_o(csr_req), .csr_idx_o(csr_idx), .csr_rdata_i(csr_rdata),
        .fencei_done_i(fencei_done),
        .flush_i(flush), .flush_pc_i(flush_pc),
        .npc_valid_o(npc_valid), .npc_ready_i(npc_ready), .npc_o(npc),
        .pred_taken_o(pred_taken), .pred_pc_o(pred_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] npc;
        logic        taken;
        logic [31:0] ppc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_ppc;   // model copy of the last predicted target

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what fetch address and prediction an instruction resolves to.
    function automatic exp_t model(input int cls, input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [31:0] rdata, input logic [11:0] csridx);
        exp_t e;
        case (cls)
            C_JAL:  begin e.npc = pc + imm; e.taken = 1'b1; end
            C_BXX:  begin
                if ($signed(imm) < 0) begin e.npc = pc + imm; e.taken = 1'b1; end
                else                  begin e.npc = pc + 4;   e.taken = 1'b0; end
            end
            C_JALR: begin e.npc = ((rdata + imm) >> 1) << 1; e.taken = 1'b1; end
            C_CSR:  begin
                e.npc   = (csridx == 12'h305) ? ((rdata >> 2) << 2) : ((rdata >> 1) << 1);
                e.taken = 1'b1;
            end
            default: begin e.npc = pc + 4; e.taken = 1'b0; end
        endcase
        e.ppc = e.npc;
        return e;
    endfunction

    task automatic push_flush(input logic [31:0] fpc);
        exp_t e;
        e.npc = fpc; e.taken = 1'b0; e.ppc = m_ppc;
        sb_q.push_back(e);
    endtask

    task automatic clear_dec();
        inst_valid = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0; dec_csr = 0; dec_fencei = 0;
        dec_immb = $urandom;
    endtask

    // Monitor: after an accept or flush, the next valid fetch address is checked.
    initial begin : monitor
        bit   pending;
        exp_t e;
        pending = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pending = 0;
                continue;
            end
            if (pending && npc_valid) begin
                pending = 0;
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sb_empty: got npc %h expected no new target", npc);
                end else begin
                    e = sb_q.pop_front();
                    check("npc", npc, e.npc);
                    check("pred_taken", 32'(pred_taken), 32'(e.taken));
                    check("pred_pc", pred_pc, e.ppc);
                end
            end
            if ((inst_valid && inst_ready) || flush) pending = 1;
        end
    end

    // One instruction: optional npc_ready stall, accept, then its wait phase.
    // wait_n: JALR busy cycles (0 = ready at once) or FENCE.I completion delay.
    // do_flush: redirect in the cycle the wait would otherwise resolve.
    task automatic run_inst(input int cls, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] rdata, input logic [4:0] rs1,
                            input logic [11:0] csridx, input int stall, input int wait_n,
                            input bit do_flush, input logic [31:0] fpc);
        exp_t e;
        @(posedge clock); #1;
        inst_valid = 1; inst_pc = pc; dec_immb = imm; dec_rs1 = rs1; dec_rs1en = 1;
        dec_csridx = csridx; rs1_rdata = rdata; csr_rdata = rdata;
        dec_jal = (cls == C_JAL); dec_jalr = (cls == C_JALR); dec_bxx = (cls == C_BXX);
        dec_csr = (cls == C_CSR); dec_fencei = (cls == C_FENCEI);
        rs1_busy = (cls == C_JALR) && (wait_n > 0);
        npc_ready = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_ready", 32'(inst_ready), 32'd0);
            @(posedge clock); #1;
        end
        npc_ready = 1;
        @(negedge clock);
        check("accept_ready", 32'(inst_ready), 32'd1);
        if (cls == C_JALR) begin
            check("rs1_req", 32'(rs1_req), 32'd1);
            check("rs1_idx", 32'(rs1_idx), 32'(rs1));
        end
        if (cls == C_CSR) begin
            check("csr_req", 32'(csr_req), 32'd1);
            check("csr_idx", 32'(csr_idx), 32'(csridx));
        end
        e = model(cls, pc, imm, rdata, csridx);
        if (!do_flush) begin
            sb_q.push_back(e);
            m_ppc = e.ppc;
        end
        @(posedge clock); #1;
        clear_dec();
        if (cls == C_JALR && wait_n > 0) begin
            for (int i = 1; i < wait_n; i++) begin
                @(negedge clock);
                check("rs1_wait_valid", 32'(npc_valid), 32'd0);
                check("rs1_wait_req", 32'(rs1_req), 32'd1);
                check("rs1_wait_idx", 32'(rs1_idx), 32'(rs1));
                @(posedge clock); #1;
            end
            rs1_busy = 0;
            if (do_flush) begin
                flush = 1; flush_pc = fpc; inst_valid = 1; dec_jal = 1; push_flush(fpc);
            end
            @(negedge clock);
            check("rs1_last_valid", 32'(npc_valid), 32'd0);
            if (do_flush) check("flush_wait_ready", 32'(inst_ready), 32'd0);
            @(posedge clock); #1;
            flush = 0; clear_dec();
        end else if (cls == C_CSR) begin
            if (do_flush) begin flush = 1; flush_pc = fpc; push_flush(fpc); end
            @(negedge clock);
            check("csr_wait_valid", 32'(npc_valid), 32'd0);
            check("csr_req_once", 32'(csr_req), 32'd0);
            @(posedge clock); #1;
            flush = 0; csr_rdata = $urandom;
        end else if (cls == C_FENCEI) begin
            for (int i = 1; i < wait_n; i++) begin
                @(negedge clock);
                check("fencei_wait_valid", 32'(npc_valid), 32'd0);
                @(posedge clock); #1;
            end
            fencei_done = 1;
            if (do_flush) begin flush = 1; flush_pc = fpc; push_flush(fpc); end
            @(negedge clock);
            check("fencei_last_valid", 32'(npc_valid), 32'd0);
            @(posedge clock); #1;
            fencei_done = 0; flush = 0;
        end
        if (do_flush) m_ppc = m_ppc;  // a redirect leaves the last prediction in place
    endtask

    // Flush while in RUN with an instruction on offer: it must not be taken.
    task automatic run_flush_run(input logic [31:0] fpc);
        @(posedge clock); #1;
        inst_valid = 1; dec_jal = 1; inst_pc = $urandom & ~32'd3; npc_ready = 1;
        flush = 1; flush_pc = fpc;
        push_flush(fpc);
        @(negedge clock);
        check("flush_run_ready", 32'(inst_ready), 32'd0);
        @(posedge clock); #1;
        flush = 0; clear_dec();
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          cls, wn, st;
        bit          fl;
        logic [31:0] pc, imm, rd;
        logic [11:0] ci;
        m_ppc = '0;
        reset = 1; npc_ready = 1; clear_dec(); inst_pc = 0; dec_rs1 = 0; dec_rs1en = 0;
        dec_csridx = 0; rs1_busy = 0; rs1_rdata = 0; csr_rdata = 0; fencei_done = 0;
        flush = 0; flush_pc = 0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rst_npc", npc, RESET_PC);
        check("rst_npc_valid", 32'(npc_valid), 32'd1);
        check("rst_inst_ready", 32'(inst_ready), 32'd0);
        check("rst_rs1_req", 32'(rs1_req), 32'd0);
        check("rst_csr_req", 32'(csr_req), 32'd0);
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_pred_pc", pred_pc, 32'd0);

        run_inst(C_BXX, 32'h8000_0010, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, 0, 0);
        run_inst(C_BXX, 32'h8000_0010, 32'h0000_0008, 0, 0, 0, 0, 0, 0, 0);
        run_inst(C_JALR, 32'h8000_0020, 32'd3, 32'h100, 5'd5, 0, 0, 3, 0, 0);
        run_inst(C_CSR, 32'h8000_0030, 0, 32'h8000_0044, 0, 12'h341, 0, 0, 0, 0);
        run_inst(C_CSR, 32'h8000_0034, 0, 32'h8000_0107, 0, 12'h305, 0, 0, 0, 0);
        run_inst(C_FENCEI, 32'h0000_0200, 0, 0, 0, 0, 0, 5, 0, 0);
        run_inst(C_JALR, 32'h8000_0040, 32'd8, 32'h400, 5'd7, 0, 0, 2, 1, 32'h300);
        run_inst(C_NONE, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 0, 0, 0);
        run_inst(C_JAL, 32'h0000_1000, 32'hFFFF_F000, 0, 0, 0, 2, 0, 0, 0);
        run_inst(C_JALR, 32'h8000_0050, 32'd5, 32'h2000, 5'd1, 0, 0, 0, 0, 0);
        run_inst(C_FENCEI, 32'h0000_0400, 0, 0, 0, 0, 0, 2, 1, 32'h500);
        run_flush_run(32'h0000_0600);

        // Reset in the middle of a CSR read drops it.
        @(posedge clock); #1;
        inst_valid = 1; dec_csr = 1; dec_csridx = 12'h305; csr_rdata = 32'h1234_5678;
        inst_pc = 32'h8000_0100; npc_ready = 1;
        @(negedge clock);
        check("midrst_csr_req", 32'(csr_req), 32'd1);
        @(posedge clock); #1;
        clear_dec(); reset = 1;
        #1;
        check("midrst_npc", npc, RESET_PC);
        check("midrst_valid", 32'(npc_valid), 32'd1);
        check("midrst_taken", 32'(pred_taken), 32'd0);
        m_ppc = '0;
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        check("midrst_csr_idle", 32'(csr_req), 32'd0);
        check("midrst_hold_npc", npc, RESET_PC);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                run_flush_run($urandom & ~32'd3);
                continue;
            end
            cls = $urandom_range(0, 5);
            pc  = $urandom & ~32'd3;
            imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            rd  = $urandom;
            ci  = ($urandom_range(0, 1) == 0) ? 12'h305 : 12'h341;
            st  = $urandom_range(0, 2);
            wn  = (cls == C_JALR) ? $urandom_range(0, 3) : $urandom_range(1, 4);
            fl  = ($urandom_range(0, 5) == 0) &&
                  ((cls == C_JALR && wn > 0) || cls == C_CSR || cls == C_FENCEI);
            run_inst(cls, pc, imm, rd, 5'($urandom_range(1, 31)), ci, st, wn, fl,
                     $urandom & ~32'd3);
        end

        repeat (3) @(posedge clock);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
